// File: rtl/casio_pkg.sv
// Shared types and limits for the casio wristwatch core.
package casio_pkg;

  typedef enum logic [1:0] {
    MODE_TIME      = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_t;

  // 0 hour-tens, 1 hour-units, 2 minute-tens, 3 minute-units
  typedef logic [1:0] digit_idx_t;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

endpackage

// File: rtl/casio_digit_editor.sv
// Four-digit BCD HH:MM entry buffer with digit index and a same-edge commit strobe.
// When toggle and confirm are pressed together, toggle wins.
module casio_digit_editor
  import casio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic       active,
  input  logic       toggle_p,
  input  logic       confirm_p,
  output logic [4:0] buf_hours,
  output logic [5:0] buf_minutes,
  output logic       commit
);

  logic [1:0] ht;
  logic [3:0] hu;
  logic [2:0] mt;
  logic [3:0] mu;
  digit_idx_t idx;

  assign buf_hours   = 5'(ht) * 5'd10 + 5'(hu);
  assign buf_minutes = 6'(mt) * 6'd10 + 6'(mu);
  assign commit      = active & confirm_p & ~toggle_p & (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ht  <= '0;
      hu  <= '0;
      mt  <= '0;
      mu  <= '0;
      idx <= '0;
    end else if (load) begin
      ht  <= 2'(load_hours / 5'd10);
      hu  <= 4'(load_hours % 5'd10);
      mt  <= 3'(load_minutes / 6'd10);
      mu  <= 4'(load_minutes % 6'd10);
      idx <= '0;
    end else if (active && toggle_p) begin
      case (idx)
        2'd0: begin
          if (ht == 2'd2) begin
            ht <= 2'd0;
          end else begin
            ht <= ht + 2'd1;
            // reaching 2x must not leave an illegal 24..29
            if (ht == 2'd1 && hu > 4'd3) hu <= 4'd0;
          end
        end
        2'd1: hu <= (hu == ((ht == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : hu + 4'd1;
        2'd2: mt <= (mt == 3'd5) ? 3'd0 : mt + 3'd1;
        default: mu <= (mu == 4'd9) ? 4'd0 : mu + 4'd1;
      endcase
    end else if (active && confirm_p) begin
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/casio.sv
// Wristwatch core: time of day, time/alarm entry, alarm ringer and lap stopwatch.
module casio
  import casio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       toggle,
  input  logic       confirm,
  input  logic       Mode,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic       ring,
  output logic [5:0] LapM,
  output logic [5:0] LapS
);

  mode_t mode_q, mode_d;
  logic toggle_q, confirm_q, mode_btn_q;
  logic toggle_p, confirm_p, mode_p;
  logic [4:0] tod_h, al_h, t_buf_h, a_buf_h;
  logic [5:0] tod_m, tod_s, al_m, t_buf_m, a_buf_m;
  logic t_commit, a_commit, armed, silenced, match, sil_press;
  logic sw_run, sw_mode;
  logic [5:0] sw_m, sw_s, sw_m_n, sw_s_n;

  assign toggle_p  = toggle & ~toggle_q;
  assign confirm_p = confirm & ~confirm_q;
  assign mode_p    = Mode & ~mode_btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_TIME;
      toggle_q   <= 1'b0;
      confirm_q  <= 1'b0;
      mode_btn_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      toggle_q   <= toggle;
      confirm_q  <= confirm;
      mode_btn_q <= Mode;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    hours   = tod_h;
    minutes = tod_m;
    if (mode_p) mode_d = mode_t'(mode_q + 2'd1);
    case (mode_q)
      MODE_SET_TIME:  begin hours = t_buf_h; minutes = t_buf_m; end
      MODE_SET_ALARM: begin hours = a_buf_h; minutes = a_buf_m; end
      // hours field is 5 bits wide, so stopwatch minutes show modulo 32
      MODE_STOPWATCH: begin hours = 5'(sw_m); minutes = sw_s; end
      default: ;
    endcase
  end

  casio_digit_editor u_time_edit (
    .clk(clk), .rst(rst),
    .load(mode_p && mode_d == MODE_SET_TIME),
    .load_hours(tod_h), .load_minutes(tod_m),
    .active(mode_q == MODE_SET_TIME && !mode_p),
    .toggle_p(toggle_p), .confirm_p(confirm_p),
    .buf_hours(t_buf_h), .buf_minutes(t_buf_m), .commit(t_commit)
  );

  casio_digit_editor u_alarm_edit (
    .clk(clk), .rst(rst),
    .load(mode_p && mode_d == MODE_SET_ALARM),
    .load_hours(al_h), .load_minutes(al_m),
    .active(mode_q == MODE_SET_ALARM && !mode_p),
    .toggle_p(toggle_p), .confirm_p(confirm_p),
    .buf_hours(a_buf_h), .buf_minutes(a_buf_m), .commit(a_commit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tod_h <= '0;
      tod_m <= '0;
      tod_s <= '0;
    end else begin
      tod_s <= (tod_s == MAX_SEC) ? 6'd0 : tod_s + 6'd1;
      if (t_commit) begin
        tod_h <= t_buf_h;
        tod_m <= t_buf_m;
      end else if (tod_s == MAX_SEC) begin
        if (tod_m == MAX_MIN) begin
          tod_m <= 6'd0;
          tod_h <= (tod_h == MAX_HOUR) ? 5'd0 : tod_h + 5'd1;
        end else begin
          tod_m <= tod_m + 6'd1;
        end
      end
    end
  end

  assign match     = armed && tod_h == al_h && tod_m == al_m;
  assign sil_press = mode_q == MODE_TIME && confirm_p && !mode_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b0;
      al_h     <= '0;
      al_m     <= '0;
      silenced <= 1'b0;
      ring     <= 1'b0;
    end else begin
      if (a_commit) begin
        al_h  <= a_buf_h;
        al_m  <= a_buf_m;
        armed <= 1'b1;
      end
      silenced <= match & (silenced | sil_press);
      ring     <= match & ~silenced & ~sil_press;
    end
  end

  assign sw_mode = mode_q == MODE_STOPWATCH && !mode_p;

  always_comb begin
    sw_s_n = sw_s;
    sw_m_n = sw_m;
    if (sw_run) begin
      if (sw_s == MAX_SEC) begin
        sw_s_n = 6'd0;
        sw_m_n = (sw_m == MAX_MIN) ? 6'd0 : sw_m + 6'd1;
      end else begin
        sw_s_n = sw_s + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_run <= 1'b0;
      sw_m   <= '0;
      sw_s   <= '0;
      LapM   <= '0;
      LapS   <= '0;
    end else begin
      sw_m <= sw_m_n;
      sw_s <= sw_s_n;
      if (sw_mode && toggle_p) begin
        sw_run <= ~sw_run;
      end else if (sw_mode && confirm_p) begin
        if (sw_run) begin
          LapM <= sw_m_n;
          LapS <= sw_s_n;
        end else begin
          sw_m <= 6'd0;
          sw_s <= 6'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_casio.sv
// Randomized and directed bench for casio against a seconds-count reference model.
module tb_casio;

  logic clk = 1'b0, rst = 1'b0, toggle = 1'b0, confirm = 1'b0, Mode = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, LapM, LapS;
  logic ring;

  casio dut (
    .clk(clk), .rst(rst), .toggle(toggle), .confirm(confirm), .Mode(Mode),
    .hours(hours), .minutes(minutes), .ring(ring), .LapM(LapM), .LapS(LapS)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // reference state: whole seconds of day, stopwatch seconds, alarm as minute of day
  int m_mode, m_tod, m_sw, m_alarm, m_lapm, m_laps;
  bit m_run, m_armed, m_sil, m_ring;
  bit pv_t, pv_c, pv_m;
  int dig[2][4];
  int idx[2];

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int edit_hm(input int e);
    return (dig[e][0] * 10 + dig[e][1]) * 60 + dig[e][2] * 10 + dig[e][3];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tod = 0; m_sw = 0; m_alarm = 0; m_lapm = 0; m_laps = 0;
    m_run = 0; m_armed = 0; m_sil = 0; m_ring = 0;
    pv_t = 0; pv_c = 0; pv_m = 0;
    for (int e = 0; e < 2; e++) begin
      idx[e] = 0;
      for (int d = 0; d < 4; d++) dig[e][d] = 0;
    end
  endtask

  task automatic load_edit(input int e, input int hm);
    dig[e][0] = (hm / 60) / 10;
    dig[e][1] = (hm / 60) % 10;
    dig[e][2] = (hm % 60) / 10;
    dig[e][3] = (hm % 60) % 10;
    idx[e] = 0;
  endtask

  task automatic inc_digit(input int e);
    case (idx[e])
      0: begin
        dig[e][0] = (dig[e][0] + 1) % 3;
        if (dig[e][0] == 2 && dig[e][1] > 3) dig[e][1] = 0;
      end
      1: dig[e][1] = (dig[e][1] + 1) % ((dig[e][0] == 2) ? 4 : 10);
      2: dig[e][2] = (dig[e][2] + 1) % 6;
      default: dig[e][3] = (dig[e][3] + 1) % 10;
    endcase
  endtask

  task automatic model_step(input bit t, input bit c, input bit m);
    bit pt, pc, pm, match, sp;
    int nt, e;
    pt = t && !pv_t; pc = c && !pv_c; pm = m && !pv_m;
    pv_t = t; pv_c = c; pv_m = m;
    match = m_armed && (m_tod / 60 == m_alarm);
    sp = pc && !pm && m_mode == 0;
    m_ring = match && !m_sil && !sp;
    m_sil = match && (m_sil || sp);
    nt = (m_tod + 1) % 86400;
    if (m_run) m_sw = (m_sw + 1) % 3600;
    if (pm) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 1) load_edit(0, m_tod / 60);
      else if (m_mode == 2) load_edit(1, m_alarm);
    end else if (m_mode == 1 || m_mode == 2) begin
      e = m_mode - 1;
      if (pt) inc_digit(e);
      else if (pc) begin
        if (idx[e] == 3) begin
          idx[e] = 0;
          if (e == 0) nt = edit_hm(0) * 60 + nt % 60;
          else begin m_alarm = edit_hm(1); m_armed = 1; end
        end else idx[e]++;
      end
    end else if (m_mode == 3) begin
      if (pt) m_run = !m_run;
      else if (pc) begin
        if (m_run) begin m_lapm = m_sw / 60; m_laps = m_sw % 60; end
        else m_sw = 0;
      end
    end
    m_tod = nt;
  endtask

  task automatic check_all();
    int eh, em;
    case (m_mode)
      0: begin eh = m_tod / 3600; em = (m_tod / 60) % 60; end
      1, 2: begin eh = dig[m_mode-1][0] * 10 + dig[m_mode-1][1];
                  em = dig[m_mode-1][2] * 10 + dig[m_mode-1][3]; end
      default: begin eh = (m_sw / 60) % 32; em = m_sw % 60; end
    endcase
    chk("hours", int'(hours), eh);
    chk("minutes", int'(minutes), em);
    chk("ring", int'(ring), int'(m_ring));
    chk("lapm", int'(LapM), m_lapm);
    chk("laps", int'(LapS), m_laps);
  endtask

  task automatic cyc(input bit t, input bit c, input bit m);
    toggle = t; confirm = c; Mode = m;
    @(posedge clk);
    model_step(t, c, m);
    #1;
    check_all();
  endtask

  task automatic press(input bit t, input bit c, input bit m);
    cyc(t, c, m);
    cyc(0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    toggle = 0; confirm = 0; Mode = 0;
    rst = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1;
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 4 && m_mode != target; k++) press(0, 0, 1);
    chk("goto_mode", m_mode, target);
  endtask

  // drives digit entry until the reference buffer holds the target, then commits
  task automatic set_entry(input int target_mode, input int h, input int mn);
    int tgt[4];
    int e;
    tgt[0] = h / 10; tgt[1] = h % 10; tgt[2] = mn / 10; tgt[3] = mn % 10;
    goto_mode(target_mode);
    e = target_mode - 1;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 10 && dig[e][d] != tgt[d]; k++) press(1, 0, 0);
      press(0, 1, 0);
    end
    goto_mode(0);
  endtask

  initial begin
    int hm, ring_seen;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1;

    // idle minute rollover
    idle(59);
    chk("min_at_59", int'(minutes), 0);
    cyc(0, 0, 0);
    chk("min_at_60", int'(minutes), 1);

    // alarm at 00:02 entered digit by digit
    do_reset();
    press(0, 0, 1); press(0, 0, 1);
    press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0);
    chk("alarm_disp", int'(minutes), 2);
    press(0, 1, 0);
    press(0, 0, 1); press(0, 0, 1);
    idle(200);

    // time set to 17:39
    do_reset();
    press(0, 0, 1); press(1, 0, 0); press(0, 1, 0);
    for (int i = 0; i < 7; i++) press(1, 0, 0);
    press(0, 1, 0);
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    press(0, 1, 0);
    for (int i = 0; i < 9; i++) press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    chk("set_hours", int'(hours), 17);
    chk("set_minutes", int'(minutes), 39);
    idle(90);

    // stopwatch run, lap, stop, clear
    do_reset();
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    cyc(1, 0, 0);
    idle(50);
    chk("sw_50", int'(minutes), 50);
    cyc(0, 1, 0);
    chk("lap_m", int'(LapM), 0);
    chk("lap_s", int'(LapS), 51);
    idle(5);
    press(1, 0, 0);
    idle(3);
    press(0, 1, 0);
    chk("sw_clear", int'(minutes), 0);
    chk("lap_kept", int'(LapS), 51);

    // hour-units wrap under hour-tens 2, then reset mid-edit
    press(0, 0, 1); press(0, 0, 1);
    press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
    for (int i = 0; i < 4; i++) press(1, 0, 0);
    chk("hu_wrap", int'(hours), 20);
    press(1, 0, 0);
    do_reset();
    chk("rst_hours", int'(hours), 0);

    // day wrap and silenced alarm
    set_entry(1, 23, 59);
    idle(70);
    hm = (m_tod / 60 + 1) % 1440;
    set_entry(2, hm / 60, hm % 60);
    ring_seen = 0;
    for (int i = 0; i < 150 && !ring_seen; i++) begin
      cyc(0, 0, 0);
      ring_seen = int'(ring);
    end
    chk("ring_rise", ring_seen, 1);
    press(0, 1, 0);
    chk("ring_silenced", int'(ring), 0);
    idle(80);

    // random button traffic with occasional directed entries
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 250; i++)
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      if (r % 3 == 0) begin
        cyc(0, 0, 0);
        hm = (m_tod / 60 + 1) % 1440;
        set_entry(2, hm / 60, hm % 60);
      end else if (r % 3 == 1) begin
        cyc(0, 0, 0);
        set_entry(1, $urandom_range(0, 23), $urandom_range(0, 59));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
